face_integral_gen: RTL and testbench
====================================

# face_integral_gen

Streaming integral-image generator for the face-detection cores. It accepts raw 8-bit grayscale pixels in row-major order, one pixel per handshake. For each pixel it emits the summed-area value ii(x,y) = sum of p(i,j) over i<=x, j<=y, in the same order. Its output stream is the per-core image that the Haar-filter detection cores load, typically a square tile of side 3*unit_size; it is the writer side of that image interface.

## Interface
Parameters:
- MAX_WIDTH, 1024, maximum row length in pixels; sets line-buffer depth.
- PIX_W, 8, input pixel width.
- SUM_W, 32, output sum width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a frame when idle.
- cfg_width  in  $clog2(MAX_WIDTH)+1  row length; sampled on accepted start.
- cfg_height  in  16  row count; sampled on accepted start.
- in_valid  in  1  pixel valid.
- in_ready  out  1  pixel accepted when in_valid && in_ready.
- in_pix  in  PIX_W  unsigned pixel.
- out_valid  out  1  sum valid.
- out_ready  in  1  downstream accept.
- out_sum  out  SUM_W  integral value.
- out_last  out  1  marks the final element of the frame.
- busy  out  1  high when not IDLE.
- done  out  1  one-cycle pulse when the frame is complete.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN on start:
  - latches cfg_width and cfg_height;
  - sets x=0, y=0, row_sum=0.
- If the latched width or height is 0: go to DRAIN instead of RUN, with no output.
- start in RUN or DRAIN is ignored. A cfg_* change mid-frame has no effect.
- Per accepted pixel:
  - rs = row_sum + in_pix.
  - above = (y==0) ? 0 : line_buf[x].
  - ii = rs + above.
  - line_buf[x] <= ii; row_sum <= rs; output register <= ii.
- At x == width-1: x <= 0, row_sum <= 0, y <= y+1. Otherwise x <= x+1.
- The line buffer is never cleared. The y==0 gating makes stale contents irrelevant.
- in_ready = (state==RUN) && (!out_valid || out_ready). This gives a single output register with full throughput.
- On acceptance of the last pixel (x==width-1, y==height-1):
  - that element's out_last is set;
  - state -> DRAIN.
- DRAIN -> IDLE when the last element handshakes out (or immediately for zero dimensions). done pulses on the transition cycle.
- Arithmetic: all unsigned, computed internally at SUM_W+1 bits. Overflow handling is per Configuration.

## Timing
- Reset values:
  - in_ready=0, out_valid=0, out_sum=0, out_last=0, busy=0, done=0;
  - state IDLE, counters 0.
- Latency: a pixel accepted at edge N shows its out_sum at N+1 (out_valid high after N).
- out_valid, out_sum and out_last hold stable while out_ready is low.
- Acceptance of a new pixel and drain of the current output can occur in the same cycle. In that cycle the register takes the new value and out_valid stays high.
- busy rises the cycle after an accepted start and falls with done.
- Zero-dimension frame: done pulses exactly 1 cycle after start (IDLE -> DRAIN -> IDLE).
- Reset mid-frame: asynchronous return to reset values. The next frame is unaffected by partial data.
- Sustained throughput: 1 pixel/cycle with in_valid and out_ready held high.

## Configuration
- FACE_II_SAT_EN
  - Defined: any ii exceeding 2^SUM_W-1 is clamped to 2^SUM_W-1, both on output and in line_buf. Clamped values propagate: later sums stay saturated.
  - Undefined: ii wraps modulo 2^SUM_W.
  - Default build (SUM_W=32, 1024x1024x255) cannot overflow, so the two builds give identical results.

## Test plan
- 3x3 frame, all pixels 1, out_ready=1:
  - outputs 1,2,3,2,4,6,3,6,9;
  - out_last only on 9;
  - done 1 cycle after the last handshake.
- Same frame, out_ready low for 5 cycles after the 4th output:
  - out_sum holds at 2 and in_ready stays low;
  - the remaining sequence is unchanged, with no loss or duplication.
- SUM_W=10, 3x2 frame of 255:
  - with FACE_II_SAT_EN: 255,510,765,510,1020,1023;
  - without it: 255,510,765,510,1020,506.
- Reset asserted after the 2nd pixel of a 2x2 frame, then start with pixels 1,2,3,4 -> 1,3,4,10.
- cfg_width=0, start:
  - no out_valid;
  - busy high 1 cycle;
  - done pulse 1 cycle after start.
- start pulsed mid-frame with different cfg_width: ignored; the frame completes with the original dimensions.

Source files
------------

// File: rtl/face_integral_gen.sv
// Streaming integral-image generator: emits ii(x,y) for raw row-major pixels, one per handshake.
// Build option FACE_II_SAT_EN: clamp sums at 2^SUM_W-1 instead of wrapping modulo 2^SUM_W.
module face_integral_gen #(
  parameter int unsigned MAX_WIDTH = 1024,
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned SUM_W     = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [$clog2(MAX_WIDTH):0] cfg_width,
  input  logic [15:0]                cfg_height,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PIX_W-1:0]           in_pix,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SUM_W-1:0]           out_sum,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned WW = $clog2(MAX_WIDTH) + 1;
  localparam int unsigned XW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
`ifdef FACE_II_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [WW-1:0]    width_q, width_d;
  logic [15:0]      height_q, height_d;
  logic [15:0]      y_q, y_d;
  logic [XW-1:0]    x_q, x_d;
  logic [SUM_W-1:0] row_sum_q, row_sum_d;
  logic [SUM_W-1:0] out_sum_q, out_sum_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             done_q, done_d;

  // Holds the previous row's integral values; never cleared, row 0 ignores it.
  logic [SUM_W-1:0] line_buf [MAX_WIDTH];

  logic             accept, last_x, last_y;
  logic [SUM_W:0]   rs, ii;
  logic [SUM_W-1:0] rs_c, ii_c, above;

  assign in_ready  = (state_q == StRun) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign last_x    = (WW'(x_q) == width_q - WW'(1));
  assign last_y    = (y_q == height_q - 16'd1);
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;

  // One guard bit catches overflow; it either forces all-ones or is dropped (wrap).
  always_comb begin
    rs    = {1'b0, row_sum_q} + (SUM_W + 1)'(in_pix);
    rs_c  = rs[SUM_W-1:0] | {SUM_W{rs[SUM_W] & SatEn}};
    above = (y_q == 16'd0) ? '0 : line_buf[x_q];
    ii    = {1'b0, rs_c} + {1'b0, above};
    ii_c  = ii[SUM_W-1:0] | {SUM_W{ii[SUM_W] & SatEn}};
  end

  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    height_d    = height_q;
    x_d         = x_q;
    y_d         = y_q;
    row_sum_d   = row_sum_q;
    out_sum_d   = out_sum_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;

    if (accept) begin
      out_valid_d = 1'b1;
      out_sum_d   = ii_c;
      out_last_d  = last_x && last_y;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          width_d   = cfg_width;
          height_d  = cfg_height;
          x_d       = '0;
          y_d       = '0;
          row_sum_d = '0;
          state_d   = (cfg_width == '0 || cfg_height == '0) ? StDrain : StRun;
        end
      end
      StRun: begin
        if (accept) begin
          if (last_x) begin
            x_d       = '0;
            y_d       = y_q + 16'd1;
            row_sum_d = '0;
            if (last_y) state_d = StDrain;
          end else begin
            x_d       = x_q + XW'(1);
            row_sum_d = rs_c;
          end
        end
      end
      StDrain: begin
        // Zero-dimension frames arrive here with nothing pending and leave at once.
        if (!out_valid_q || out_ready) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      width_q     <= '0;
      height_q    <= '0;
      x_q         <= '0;
      y_q         <= '0;
      row_sum_q   <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      x_q         <= x_d;
      y_q         <= y_d;
      row_sum_q   <= row_sum_d;
      out_sum_q   <= out_sum_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) line_buf[x_q] <= ii_c;
  end

endmodule

// File: tb/tb_face_integral_gen.sv
// Bench for face_integral_gen: a 32-bit and a 10-bit instance share one stimulus stream.
// Expected sums come from a table and from a direct summed-area model (wrap or clamp).
module tb_face_integral_gen;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, out_ready;
  logic [6:0]  cfg_width;
  logic [15:0] cfg_height;
  logic [7:0]  in_pix;
  logic        in_ready, out_valid, out_last, busy, done;
  logic [31:0] out_sum;
  logic        in_ready_b, out_valid_b, out_last_b, busy_b, done_b;
  logic [9:0]  out_sum_b;

`ifdef FACE_II_SAT_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  always #5 clk = ~clk;

  face_integral_gen #(.MAX_WIDTH(64), .PIX_W(8), .SUM_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_last(out_last), .busy(busy), .done(done)
  );

  face_integral_gen #(.MAX_WIDTH(64), .PIX_W(8), .SUM_W(10)) dut10 (
    .clk(clk), .reset(reset), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_pix(in_pix), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_sum(out_sum_b), .out_last(out_last_b), .busy(busy_b),
    .done(done_b)
  );

  int passed = 0;
  int total  = 0;
  int waits  = 0;
  int hs_cnt = 0;
  bit chk_done_en = 1'b1;
  bit rnd = 1'b0;
  longint obs32[$];
  longint obs10[$];
  bit     obs_last[$];
  bit     obs_last_b[$];

  typedef struct packed {
    logic [7:0]       w;
    logic [7:0]       h;
    logic [8:0][7:0]  pix;
    logic [8:0][31:0] e32;
    logic [8:0][31:0] e10;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic fail_msg(input string name);
    total++;
    $display("FAIL %s: timed out", name);
  endtask

  // Direct definition: ii(x,y) = sum of p(i,j) for i<=x, j<=y, then wrap or clamp.
  function automatic void model(input int w, input int h, input int pix[$], input int sw,
                                input bit sat, output longint e[$]);
    longint t, m;
    m = (longint'(1) << sw) - 1;
    e = {};
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        t = 0;
        for (int j = 0; j <= y; j++)
          for (int i = 0; i <= x; i++) t += pix[j*w+i];
        if (sat) e.push_back((t > m) ? m : t);
        else e.push_back(t & m);
      end
  endfunction

  // Output monitor, sampled on the falling edge.
  bit     prev_last, prev_hold;
  longint hold_sum;
  always @(negedge clk) begin
    if (reset) begin
      prev_last = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (chk_done_en && (done || prev_last)) begin
        check("done", done, prev_last);
        check("done_b", done_b, prev_last);
        if (prev_last) check("busy_after_done", busy, 0);
      end
      if (prev_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_sum", out_sum, hold_sum);
      end
      prev_hold = out_valid && !out_ready;
      hold_sum  = out_sum;
      prev_last = out_valid && out_ready && out_last;
      if (out_valid && out_ready) begin
        obs32.push_back(out_sum);
        obs_last.push_back(out_last);
        hs_cnt++;
      end
      if (out_valid_b && out_ready) begin
        obs10.push_back(out_sum_b);
        obs_last_b.push_back(out_last_b);
      end
    end
  end

  task automatic start_frame(input int w, input int h);
    cfg_width  = w[6:0];
    cfg_height = h[15:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_pix(input int p);
    int n = 0;
    if (rnd)
      while ($urandom_range(0, 3) == 0) begin
        in_valid  = 1'b0;
        out_ready = ($urandom_range(0, 2) != 0);
        @(posedge clk); #1;
      end
    in_valid = 1'b1;
    in_pix   = p[7:0];
    if (rnd) out_ready = ($urandom_range(0, 2) != 0);
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      waits++;
      @(posedge clk); #1;
      if (rnd) out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    if (n >= 200) fail_msg("in_ready");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_frame(input string name, input int n, input longint e32[$],
                             input longint e10[$]);
    int k = 0;
    out_ready = 1'b1;
    while (obs32.size() < n && k < 300) begin
      @(negedge clk); #1;
      k++;
    end
    if (k >= 300) fail_msg({name, " drain"});
    @(negedge clk); #1;
    check({name, " count"}, obs32.size(), n);
    check({name, " count_b"}, obs10.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < obs32.size()) begin
        check($sformatf("%s sum[%0d]", name, i), obs32[i], e32[i]);
        check($sformatf("%s last[%0d]", name, i), obs_last[i], (i == n - 1));
      end
      if (i < obs10.size()) begin
        check($sformatf("%s sum10[%0d]", name, i), obs10[i], e10[i]);
        check($sformatf("%s last10[%0d]", name, i), obs_last_b[i], (i == n - 1));
      end
    end
    check({name, " busy_end"}, busy, 0);
    check({name, " busy_b_end"}, busy_b, 0);
    check({name, " in_ready_b_end"}, in_ready_b, 0);
    @(posedge clk); #1;
    obs32 = {}; obs10 = {}; obs_last = {}; obs_last_b = {};
    hs_cnt = 0;
  endtask

  task automatic set_vec(input int idx, input int w, input int h, input int p[9],
                         input int a[9], input int b[9]);
    vecs[idx].w = w[7:0];
    vecs[idx].h = h[7:0];
    for (int i = 0; i < 9; i++) begin
      vecs[idx].pix[i] = p[i][7:0];
      vecs[idx].e32[i] = a[i];
      vecs[idx].e10[i] = b[i];
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tp[9], ta[9], tb[9];
    int pq[$];
    longint e32[$], e10[$];
    int w, h, n;

    tp = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    ta = '{1, 2, 3, 2, 4, 6, 3, 6, 9};
    set_vec(0, 3, 3, tp, ta, ta);
    tp = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
    ta = '{1, 3, 4, 10, 0, 0, 0, 0, 0};
    set_vec(1, 2, 2, tp, ta, ta);
    tp = '{255, 255, 255, 255, 255, 255, 0, 0, 0};
    ta = '{255, 510, 765, 510, 1020, 1530, 0, 0, 0};
`ifdef FACE_II_SAT_EN
    tb = '{255, 510, 765, 510, 1020, 1023, 0, 0, 0};
`else
    tb = '{255, 510, 765, 510, 1020, 506, 0, 0, 0};
`endif
    set_vec(2, 3, 2, tp, ta, tb);
    tp = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
    ta = '{5, 11, 18, 26, 0, 0, 0, 0, 0};
    set_vec(3, 1, 4, tp, ta, ta);
    tp = '{10, 20, 30, 40, 0, 0, 0, 0, 0};
    ta = '{10, 30, 60, 100, 0, 0, 0, 0, 0};
    set_vec(4, 4, 1, tp, ta, ta);

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_pix = '0; out_ready = 1'b1;
    cfg_width = '0; cfg_height = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", in_ready, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_sum", out_sum, 0);
    check("rst out_last", out_last, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Table-driven frames at full rate.
    for (int k = 0; k < 5; k++) begin
      w = vecs[k].w; h = vecs[k].h; n = w * h;
      pq = {}; e32 = {}; e10 = {};
      for (int i = 0; i < n; i++) begin
        pq.push_back(vecs[k].pix[i]);
        e32.push_back(vecs[k].e32[i]);
        e10.push_back(vecs[k].e10[i]);
      end
      waits = 0;
      start_frame(w, h);
      check($sformatf("vec%0d busy", k), busy, 1);
      foreach (pq[i]) send_pix(pq[i]);
      check($sformatf("vec%0d throughput stalls", k), waits, 0);
      check_frame($sformatf("vec%0d", k), n, e32, e10);
    end

    // Backpressure: stall 5 cycles while the 4th output (value 2) is presented.
    start_frame(3, 3);
    fork
      begin
        for (int i = 0; i < 9; i++) send_pix(1);
      end
      begin
        int t = 0;
        while (hs_cnt < 3 && t < 100) begin
          @(posedge clk); #1;
          t++;
        end
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall valid", out_valid, 1);
          check("stall sum", out_sum, 2);
          check("stall in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    pq = {1, 1, 1, 1, 1, 1, 1, 1, 1};
    model(3, 3, pq, 32, Sat, e32);
    model(3, 3, pq, 10, Sat, e10);
    check_frame("stall", 9, e32, e10);

    // Reset in the middle of a frame, then a clean frame.
    start_frame(2, 2);
    send_pix(7);
    send_pix(9);
    reset = 1'b1;
    #1;
    check("midrst busy", busy, 0);
    check("midrst out_valid", out_valid, 0);
    check("midrst in_ready", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    obs32 = {}; obs10 = {}; obs_last = {}; obs_last_b = {}; hs_cnt = 0;
    start_frame(2, 2);
    pq = {1, 2, 3, 4};
    foreach (pq[i]) send_pix(pq[i]);
    model(2, 2, pq, 32, Sat, e32);
    model(2, 2, pq, 10, Sat, e10);
    check_frame("after_reset", 4, e32, e10);

    // Zero-width and zero-height frames.
    chk_done_en = 1'b0;
    for (int z = 0; z < 2; z++) begin
      start_frame(z == 0 ? 0 : 2, z == 0 ? 3 : 0);
      check("zero busy", busy, 1);
      check("zero done early", done, 0);
      @(posedge clk); #1;
      check("zero busy end", busy, 0);
      check("zero done", done, 1);
      check("zero out_valid", out_valid, 0);
      @(posedge clk); #1;
      check("zero done pulse", done, 0);
      check("zero outputs", obs32.size(), 0);
    end
    chk_done_en = 1'b1;

    // start mid-frame with other dimensions is ignored.
    start_frame(3, 3);
    pq = {};
    for (int i = 0; i < 9; i++) pq.push_back($urandom_range(0, 255));
    for (int i = 0; i < 4; i++) send_pix(pq[i]);
    cfg_width = 7'd2; cfg_height = 16'd1; start = 1'b1;
    send_pix(pq[4]);
    start = 1'b0;
    for (int i = 5; i < 9; i++) send_pix(pq[i]);
    model(3, 3, pq, 32, Sat, e32);
    model(3, 3, pq, 10, Sat, e10);
    check_frame("mid_start", 9, e32, e10);

    // Random frames with input gaps and random backpressure.
    for (int f = 0; f < 12; f++) begin
      w = $urandom_range(1, 8);
      h = $urandom_range(1, 5);
      pq = {};
      for (int i = 0; i < w * h; i++) pq.push_back($urandom_range(0, 255));
      rnd = 1'b1;
      start_frame(w, h);
      foreach (pq[i]) send_pix(pq[i]);
      rnd = 1'b0;
      model(w, h, pq, 32, Sat, e32);
      model(w, h, pq, 10, Sat, e10);
      check_frame($sformatf("rnd%0d", f), w * h, e32, e10);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
